// File: rtl/cdf_lut_if.sv
// Bus bundle for the CDF-to-LUT builder: control, CDF read port and LUT write port.
interface cdf_lut_if;
    logic         start;
    logic [19:0]  cdf_min;
    logic [19:0]  pixel_total;
    logic [15:0]  base_address;
    logic [15:0]  CDF_ReadAddress;
    logic [127:0] CDF_ReadBus;
    logic         lut_we;
    logic [7:0]   lut_addr;
    logic [7:0]   lut_data;
    logic         busy;
    logic         done;

    modport master (
        output start, cdf_min, pixel_total, base_address, CDF_ReadBus,
        input  CDF_ReadAddress, lut_we, lut_addr, lut_data, busy, done
    );

    modport slave (
        input  start, cdf_min, pixel_total, base_address, CDF_ReadBus,
        output CDF_ReadAddress, lut_we, lut_addr, lut_data, busy, done
    );
endinterface

// File: rtl/cdf_lut_builder.sv
// Builds the 256-entry histogram-equalization LUT from the stored CDF table
// using a fixed-latency restoring divider per bin.
module cdf_lut_builder #(
    parameter int NUM_WORDS = 64,
    parameter int DIV_BITS  = 29
) (
    input logic      clock,
    input logic      reset,
    cdf_lut_if.slave bus
);
    localparam int WW = $clog2(NUM_WORDS);
    localparam int CW = $clog2(DIV_BITS);

    typedef enum logic [2:0] {
        IDLE, READ, LATCH, SETUP, DIV, WRITE, DONE
    } state_t;

    state_t state, nxt;

    logic [19:0]         cmin, ptot, den, rem;
    logic [15:0]         base, rd_addr;
    logic [127:0]        wreg;
    logic [WW-1:0]       word;
    logic [1:0]          lane;
    logic [CW-1:0]       cnt;
    logic [DIV_BITS-1:0] dq;
    logic                bypass, ge;
    logic [7:0]          lut_addr_q, lut_data_q;

    logic [19:0]         cdf, den_c, r_nxt;
    logic [DIV_BITS-1:0] num_c, q_fin;
    logic [20:0]         r_sh, r_sub;
    logic                qbit, last_step, last_word;
    logic                we, bsy, dn;

    always_comb begin
        cdf   = wreg[{lane, 5'd0} +: 20];
        den_c = (ptot > cmin) ? ptot - cmin : 20'd0;
        num_c = '0;
        if (cdf >= cmin)
            num_c = DIV_BITS'(cdf - cmin) * DIV_BITS'(255)
                  + DIV_BITS'(den_c >> 1);
        // Shift in the next numerator bit, subtract when it fits
        r_sh  = {rem, dq[DIV_BITS-1]};
        r_sub = r_sh - {1'b0, den};
        qbit  = (r_sh >= {1'b0, den});
        r_nxt = qbit ? r_sub[19:0] : r_sh[19:0];
        q_fin = {dq[DIV_BITS-2:0], qbit};
        last_step = (cnt == CW'(DIV_BITS - 1));
        last_word = (word == WW'(NUM_WORDS - 1));
    end

    always_comb begin
        nxt = state;
        we  = 1'b0;
        bsy = 1'b0;
        dn  = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) nxt = READ;
            READ:  begin bsy = 1'b1; nxt = LATCH; end
            LATCH: begin bsy = 1'b1; nxt = SETUP; end
            SETUP: begin bsy = 1'b1; nxt = DIV; end
            DIV: begin
                bsy = 1'b1;
                if (last_step) nxt = WRITE;
            end
            WRITE: begin
                bsy = 1'b1;
                we  = 1'b1;
                if (lane != 2'd3) nxt = SETUP;
                else if (!last_word) nxt = READ;
                else nxt = DONE;
            end
            DONE: begin dn = 1'b1; nxt = IDLE; end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cmin       <= '0;
            ptot       <= '0;
            base       <= '0;
            rd_addr    <= '0;
            wreg       <= '0;
            word       <= '0;
            lane       <= '0;
            cnt        <= '0;
            den        <= '0;
            rem        <= '0;
            dq         <= '0;
            bypass     <= 1'b0;
            ge         <= 1'b0;
            lut_addr_q <= '0;
            lut_data_q <= '0;
        end else begin
            state <= nxt;
            unique case (state)
                IDLE: if (bus.start) begin
                    cmin    <= bus.cdf_min;
                    ptot    <= bus.pixel_total;
                    base    <= bus.base_address;
                    rd_addr <= bus.base_address;
                    word    <= '0;
                    lane    <= '0;
                end
                LATCH: wreg <= bus.CDF_ReadBus;
                SETUP: begin
                    den    <= den_c;
                    dq     <= num_c;
                    rem    <= '0;
                    cnt    <= '0;
                    bypass <= (den_c == 20'd0);
                    ge     <= (cdf >= cmin);
                end
                DIV: begin
                    rem <= r_nxt;
                    dq  <= q_fin;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        lut_addr_q <= 8'({word, lane});
                        if (bypass)
                            lut_data_q <= ge ? 8'hFF : 8'h00;
                        else if (|q_fin[DIV_BITS-1:8])
                            lut_data_q <= 8'hFF;
                        else
                            lut_data_q <= q_fin[7:0];
                    end
                end
                WRITE: begin
                    if (lane != 2'd3) begin
                        lane <= lane + 1'b1;
                    end else if (!last_word) begin
                        lane    <= '0;
                        word    <= word + 1'b1;
                        rd_addr <= base + 16'(word) + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.CDF_ReadAddress = rd_addr;
    assign bus.lut_we          = we;
    assign bus.lut_addr        = lut_addr_q;
    assign bus.lut_data        = lut_data_q;
    assign bus.busy            = bsy;
    assign bus.done            = dn;
endmodule

// File: tb/tb_cdf_lut_builder.sv
// Directed + randomized bench for cdf_lut_builder with an arithmetic LUT model
// and a registered CDF memory responder.
module tb_cdf_lut_builder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdf_lut_if bus();

    cdf_lut_builder #(.NUM_WORDS(64), .DIV_BITS(29)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [19:0] cdf [256];
    logic [7:0]  lut_obs [256];
    int unsigned cyc = 0;
    int unsigned s0 = 0;
    bit active = 0;
    int nwe = 0;
    int ndone = 0;
    int e_cm = 0, e_pt = 0, e_base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model(int c, int cm, int pt);
        longint q;
        if (pt <= cm) return (c >= cm) ? 255 : 0;
        if (c < cm) return 0;
        q = (longint'(c - cm) * 255 + (pt - cm) / 2) / (pt - cm);
        return (q > 255) ? 255 : int'(q);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin : mem
        logic [127:0] w;
        logic [15:0] off;
        off = bus.CDF_ReadAddress - 16'(e_base);
        for (int i = 0; i < 4; i++)
            w[32*i +: 32] = {12'($urandom),
                             (off < 16'd64) ? cdf[int'(off)*4 + i] : 20'hABCDE};
        bus.CDF_ReadBus <= w;
    end

    always @(negedge clk) begin : mon
        int rel;
        if (active) begin
            rel = int'(cyc - s0);
            if (rel % 126 == 1 && rel / 126 < 64)
                chk("rd_addr", 32'(bus.CDF_ReadAddress),
                    32'((e_base + rel / 126) & 16'hFFFF));
            if (rel == 1 || rel == 8064) chk("busy_hi", 32'(bus.busy), 1);
            if (rel == 8065) chk("busy_lo", 32'(bus.busy), 0);
            if (bus.lut_we) begin
                chk("lut_addr", 32'(bus.lut_addr), 32'(nwe));
                chk("lut_data", 32'(bus.lut_data),
                    32'(model(int'(cdf[nwe & 255]), e_cm, e_pt)));
                chk("we_cycle", 32'(rel),
                    32'(33 + 126 * (nwe / 4) + 31 * (nwe % 4)));
                lut_obs[bus.lut_addr] = bus.lut_data;
                nwe++;
            end
            if (bus.done) begin
                chk("done_cycle", 32'(rel), 8065);
                ndone++;
            end
        end
    end

    task automatic fill_rand(int lo, int hi);
        for (int v = 0; v < 256; v++) cdf[v] = 20'($urandom_range(hi, lo));
    endtask

    task automatic start_build(int cm, int pt, int base);
        @(negedge clk);
        e_cm = cm;
        e_pt = pt;
        e_base = base;
        bus.cdf_min = 20'(cm);
        bus.pixel_total = 20'(pt);
        bus.base_address = 16'(base);
        bus.start = 1'b1;
        s0 = cyc;
        nwe = 0;
        ndone = 0;
        active = 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic finish_build();
        int n;
        n = 0;
        while (ndone == 0 && n < 9000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", 32'(ndone), 1);
        chk("we_count", 32'(nwe), 256);
        active = 0;
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_addr"}, 32'(bus.CDF_ReadAddress), 0);
        chk({tag, "_we"}, 32'(bus.lut_we), 0);
        chk({tag, "_la"}, 32'(bus.lut_addr), 0);
        chk({tag, "_ld"}, 32'(bus.lut_data), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cdf_min = '0;
        bus.pixel_total = '0;
        bus.base_address = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("rst0");
        rst = 1'b0;

        for (int v = 0; v < 256; v++) cdf[v] = 20'(v + 1);
        start_build(1, 256, 16'h0000);
        finish_build();
        chk("uniform_0", 32'(lut_obs[0]), 0);
        chk("uniform_255", 32'(lut_obs[255]), 255);

        for (int v = 0; v < 256; v++) cdf[v] = (v < 100) ? 20'd0 : 20'd4096;
        start_build(4096, 4096, 16'h1234);
        finish_build();
        chk("single_99", 32'(lut_obs[99]), 0);
        chk("single_100", 32'(lut_obs[100]), 255);

        fill_rand(10, 1010);
        cdf[0] = 20'd12;
        cdf[1] = 20'd13;
        cdf[2] = 20'd1010;
        start_build(10, 1010, 16'h0100);
        finish_build();
        chk("round_12", 32'(lut_obs[0]), 1);
        chk("round_13", 32'(lut_obs[1]), 1);
        chk("round_1010", 32'(lut_obs[2]), 255);

        fill_rand(0, 70000);
        start_build(1500, 65536, 16'hFFF0);
        finish_build();

        fill_rand(0, 300000);
        start_build(777, 300000, 16'h4000);
        repeat (498) @(negedge clk);
        bus.start = 1'b1;
        bus.cdf_min = 20'd3;
        bus.pixel_total = 20'd9;
        bus.base_address = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        finish_build();

        fill_rand(0, 150);
        cdf[7] = 20'd1150;
        start_build(50, 150, 16'h0800);
        finish_build();
        chk("saturate", 32'(lut_obs[7]), 255);

        fill_rand(0, 5000);
        start_build(100, 5000, 16'h2000);
        repeat (1999) @(negedge clk);
        rst = 1'b1;
        active = 0;
        @(negedge clk);
        chk_idle("rst_mid");
        rst = 1'b0;

        fill_rand(0, 10000);
        start_build(5000, 3000, 16'h3000);
        finish_build();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdf_lut_builder.md
Name: cdf_lut_builder

Overview:
- Consumes the CDF table that the CDF pipeline writes to output memory and converts it into the 256-entry, 8-bit histogram-equalization lookup table.
- For each bin v it computes LUT[v] = round((cdf[v] - cdf_min) * 255 / (pixel_total - cdf_min)).
- It sits downstream of the CDF store stage and upstream of the pixel remap stage, which indexes the LUT by pixel value.

Parameters:
- NUM_WORDS, 64, number of 128-bit CDF words to read (4 bins per word, 256 bins).
- DIV_BITS, 29, width of the rounded numerator and number of restoring-divide iterations.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a LUT build; sampled only in IDLE.
- cdf_min  input  20  minimum non-zero CDF value from the accumulate stage; latched at start.
- pixel_total  input  20  total pixel count (final CDF value); latched at start.
- base_address  input  16  CDF table base address in memory; latched at start.
- CDF_ReadAddress  output  16  memory read address.
- CDF_ReadBus  input  128  read data, valid exactly 1 cycle after the address is driven; lane i is bits [32i+19:32i] and holds the CDF of bin 4*word+i; bits [32i+31:32i+20] are ignored.
- lut_we  output  1  LUT write strobe, 1-cycle pulse per entry.
- lut_addr  output  8  LUT index (bin number).
- lut_data  output  8  equalized value.
- busy  output  1  high while a build is in progress.
- done  output  1  1-cycle pulse after the final LUT write.

Behaviour:
- Reset: state IDLE; CDF_ReadAddress, lut_we, lut_addr, lut_data, busy and done all 0; word and lane counters 0.
- Reset mid-build aborts immediately with no further writes. The LUT contents are then undefined until the next complete build.
- FSM states and transitions:
  - IDLE: start=1 latches operands -> READ.
  - READ: drive CDF_ReadAddress = base_address + word (16-bit, wraps mod 2^16) -> LATCH.
  - LATCH: capture CDF_ReadBus into a 128-bit word register -> SETUP.
  - SETUP: select lane; compute den = pixel_total - cdf_min.
    - If cdf < cdf_min: num = 0; otherwise num = (cdf - cdf_min)*255 + floor(den/2), 29 bits.
    - Load the divider -> DIV.
  - DIV: one restoring-divide step per cycle for exactly 29 cycles -> WRITE.
  - WRITE: lut_we=1, lut_addr = 4*word + lane, lut_data = min(quotient, 255).
    - lane<3: lane++ -> SETUP.
    - Else if word < NUM_WORDS-1: word++, lane=0 -> READ.
    - Else -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- den==0, i.e. pixel_total == cdf_min (single-valued image):
  - The divide result is bypassed: lut_data = 255 if cdf >= cdf_min, else 0.
  - The 29 DIV cycles are still spent, so timing stays data-independent.
- pixel_total < cdf_min (invalid input): den is treated as 0 under the rule above.
- Quotient > 255 (cdf > pixel_total): saturate to 255.
- Timing, with start sampled at cycle 0:
  - busy rises in cycle 1.
  - Word k READ is in cycle 1+126k.
  - The write for word k, lane j is in cycle 33+126k+31j, so the first lut_we is in cycle 33 and the last in cycle 8064.
  - done and the drop of busy both occur in cycle 8065; busy is 1 in cycles 1..8064 and 0 from cycle 8065.
- start while busy is ignored. Operand input changes while busy have no effect.
- lut_we is 0 in every state except WRITE. lut_addr and lut_data hold their last values between writes.
- CDF_ReadAddress holds its last value outside READ.

Test Plan:
- Uniform image (cdf[v]=v+1, cdf_min=1, pixel_total=256, base 0x0000) -> LUT[v]=v for all 256 bins; first lut_we at cycle 33; done at cycle 8065.
- Single-valued image (cdf[v]=0 for v<100, cdf[v]=4096 for v>=100, cdf_min=4096, pixel_total=4096) -> LUT[0..99]=0, LUT[100..255]=255 via the den==0 path, with unchanged timing.
- Rounding check (cdf_min=10, pixel_total=1010, den=1000, bin cdf=12, num=510+500=1010) -> lut_data=1; bin cdf=13 -> (765+500)/1000 -> lut_data=1; bin cdf=1010 -> 255.
- Address wrap (base_address=0xFFF0) -> read addresses 0xFFF0..0xFFFF, then 0x0000..0x002F; 64 reads total, each exactly one cycle.
- start re-pulsed at cycle 500 and operands changed mid-build -> ignored; outputs match the original operands; exactly 256 lut_we pulses, then one done.
- Saturation (a bin with cdf=pixel_total+1000, den=100) -> lut_data=255.
- Reset asserted at cycle 2000 -> next cycle all outputs 0 and state IDLE; a fresh start then completes normally with done at +8065.
